// File: rtl/my_pll_pkg.sv
// Shared constants and a parameter helper for the digital PLL stand-in.
package my_pll_pkg;

  localparam int DEF_ACC_W  = 32;
  localparam int LOCK_CNT_W = 16;

  // Rounded phase increment for a wanted output frequency; meant for parameter expressions.
  function automatic logic [DEF_ACC_W-1:0] freq_to_inc(input longint unsigned f_in_hz,
                                                        input longint unsigned f_out_hz);
    longint unsigned scaled;
    scaled = (f_out_hz << DEF_ACC_W) + (f_in_hz >> 1);
    return DEF_ACC_W'(scaled / f_in_hz);
  endfunction

endpackage

// File: rtl/my_pll_nco_clk.sv
// Phase-accumulator clock generator: output is the accumulator MSB, held at 0 while disabled.
module nco_clk #(
  parameter int              ACC_W = 32,
  parameter logic [ACC_W-1:0] INC  = ACC_W'(1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  output logic clk_out
);

  localparam longint unsigned HALF = 64'd1 << (ACC_W - 1);

  // Increments above half the accumulator range would alias below f_in/2.
  generate
    if (INC == '0 || 64'(INC) > HALF) begin : g_bad_inc
      $error("nco_clk: INC must be in 1 .. 2^(ACC_W-1)");
    end
  endgenerate

  logic [ACC_W-1:0] acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (!en) begin
      acc <= '0;
    end else begin
      acc <= acc + INC;
    end
  end

  assign clk_out = acc[ACC_W-1];

endmodule

// File: rtl/my_pll.sv
// Digital PLL stand-in: two NCO clocks gated by a lock timer, plus a pass-through clock.
module my_pll
  import my_pll_pkg::*;
#(
  parameter int               ACC_W       = DEF_ACC_W,
  parameter logic [ACC_W-1:0] C0_INC      = ACC_W'(32'h4000_0000),
  parameter logic [ACC_W-1:0] C1_INC      = ACC_W'(32'h8000_0000),
  parameter int               LOCK_CYCLES = 8
) (
  input  logic inclk0,
  input  logic areset_n,
  output logic c0,
  output logic c1,
  output logic c2,
  output logic locked
);

  generate
    if (LOCK_CYCLES < 1 || LOCK_CYCLES > 65535) begin : g_bad_lock
      $error("my_pll: LOCK_CYCLES must be in 1 .. 65535");
    end
  endgenerate

  localparam logic [LOCK_CNT_W-1:0] LOCK_TGT = LOCK_CNT_W'(LOCK_CYCLES);

  logic [LOCK_CNT_W-1:0] lock_cnt;

  // locked rises on the same edge the counter reaches its target, then sticks.
  always_ff @(posedge inclk0 or negedge areset_n) begin
    if (!areset_n) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (lock_cnt != LOCK_TGT) begin
      lock_cnt <= lock_cnt + LOCK_CNT_W'(1);
      if (lock_cnt + LOCK_CNT_W'(1) == LOCK_TGT) begin
        locked <= 1'b1;
      end
    end
  end

  nco_clk #(.ACC_W(ACC_W), .INC(C0_INC)) u_nco_c0 (
    .clk     (inclk0),
    .rst_n   (areset_n),
    .en      (locked),
    .clk_out (c0)
  );

  nco_clk #(.ACC_W(ACC_W), .INC(C1_INC)) u_nco_c1 (
    .clk     (inclk0),
    .rst_n   (areset_n),
    .en      (locked),
    .clk_out (c1)
  );

  assign c2 = inclk0;

endmodule

// File: tb/tb_my_pll.sv
// Randomised reset/run bench for my_pll with two parameterisations sharing clock and reset.
module tb_my_pll;
  import my_pll_pkg::*;

  localparam logic [31:0] A_C0 = 32'h4000_0000;
  localparam logic [31:0] A_C1 = 32'h8000_0000;
  localparam int          A_LK = 8;
  localparam logic [31:0] B_C0 = 32'h6000_0000;
  localparam logic [31:0] B_C1 = 32'h0123_4567;
  localparam int          B_LK = 1;

  logic inclk0;
  logic areset_n;
  logic c0_a, c1_a, c2_a, locked_a;
  logic c0_b, c1_b, c2_b, locked_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [5:0] exp_q[$];
  int         edges_since_rel = 0;
  logic       exp_c0a = 1'b0;

  my_pll #(.C0_INC(A_C0), .C1_INC(A_C1), .LOCK_CYCLES(A_LK)) dut_a (
    .inclk0 (inclk0), .areset_n (areset_n),
    .c0 (c0_a), .c1 (c1_a), .c2 (c2_a), .locked (locked_a)
  );

  my_pll #(.C0_INC(B_C0), .C1_INC(B_C1), .LOCK_CYCLES(B_LK)) dut_b (
    .inclk0 (inclk0), .areset_n (areset_n),
    .c0 (c0_b), .c1 (c1_b), .c2 (c2_b), .locked (locked_b)
  );

  // clock / reset
  initial inclk0 = 1'b0;
  always #5 inclk0 = ~inclk0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Reference: after n edges since release, locked = n >= L and the phase is (n-L)*INC mod 2^32.
  function automatic logic [2:0] model(input int n, input int lock_n,
                                       input logic [31:0] inc0, input logic [31:0] inc1);
    longint unsigned k;
    logic [31:0] ph0, ph1;
    if (n < lock_n) return 3'b000;
    k   = 64'(n - lock_n);
    ph0 = 32'(k * 64'(inc0));
    ph1 = 32'(k * 64'(inc1));
    return {1'b1, ph1[31], ph0[31]};
  endfunction

  always @(posedge inclk0) begin
    logic [2:0] ea, eb;
    if (!areset_n) edges_since_rel = 0;
    else           edges_since_rel++;
    ea = model(edges_since_rel, A_LK, A_C0, A_C1);
    eb = model(edges_since_rel, B_LK, B_C0, B_C1);
    exp_q.push_back({eb, ea});
    exp_c0a = ea[0];
  end

  // scoreboard monitor
  always @(negedge inclk0) begin
    logic [5:0] e, got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {locked_b, c1_b, c0_b, locked_a, c1_a, c0_a};
      n_checks++;
      if (got !== e) begin
        n_fail++;
        $display("FAIL outputs t=%0t n=%0d {lk_b,c1_b,c0_b,lk_a,c1_a,c0_a} got %b expected %b",
                 $time, edges_since_rel, got, e);
      end
    end
  end

  always @(inclk0) begin
    logic ref_clk;
    ref_clk = inclk0;
    #1;
    n_checks++;
    if ({c2_a, c2_b} !== {2{ref_clk}}) begin
      n_fail++;
      $display("FAIL c2_passthru t=%0t got %b%b expected %b", $time, c2_a, c2_b, ref_clk);
    end
  end

  task automatic check_async_reset();
    logic [5:0] got;
    #1;
    got = {locked_b, c1_b, c0_b, locked_a, c1_a, c0_a};
    n_checks++;
    if (got !== 6'b0) begin
      n_fail++;
      $display("FAIL async_reset t=%0t got %b expected 000000", $time, got);
    end
  endtask

  task automatic check_value(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", name, got, exp);
    end
  endtask

  // driver
  initial begin
    logic found;
    areset_n = 1'b0;
    check_value("freq_to_inc_25M", freq_to_inc(64'd100_000_000, 64'd25_000_000), 32'h4000_0000);
    check_value("freq_to_inc_50M", freq_to_inc(64'd100_000_000, 64'd50_000_000), 32'h8000_0000);
    repeat (3) @(negedge inclk0);
    #2 areset_n = 1'b1;

    for (int seg = 0; seg < 8; seg++) begin
      repeat ($urandom_range(4, 60)) @(negedge inclk0);
      if (seg % 2 == 0) begin
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
          @(negedge inclk0);
          found = exp_c0a;
        end
        n_checks++;
        if (!found) begin
          n_fail++;
          $display("FAIL wait_c0_high seg=%0d got 0 expected 1 within 16 cycles", seg);
        end
      end
      #2 areset_n = 1'b0;
      check_async_reset();
      repeat ($urandom_range(1, 3)) @(negedge inclk0);
      #2 areset_n = 1'b1;
    end

    repeat (40) @(negedge inclk0);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
